word_packer: RTL and testbench

//  Width-up converter placed directly downstream of the dw-bit req/ack FIFO.

---
 rtl/word_packer_pkg.sv | 14 +
 rtl/word_packer.sv | 90 +++++++++
 tb/tb_word_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/word_packer_pkg.sv
// Shared stream helpers: handshake fire and counter-width computation.
// Reused by the narrow FIFO and the wide-side stages.
package word_packer_pkg;

    function automatic logic fire(input logic req, input logic ack);
        return req & ack;
    endfunction

    // Width needed to hold a lane count of 0..k inclusive.
    function automatic int unsigned cnt_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Width-up packer: gathers K dw-bit req/ack words into one K*dw-bit word,
// with an optional flush that emits a partial word plus its valid-lane count.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int unsigned dw = 8,
    parameter int unsigned K  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [dw-1:0]                  d_in,
    input  logic                           req_in,
    output logic                           ack_in,
    input  logic                           flush,
    output logic [K*dw-1:0]                d_out,
    output logic [cnt_width(K)-1:0]        n_out,
    output logic                           req_out,
    input  logic                           ack_out
);

    localparam int unsigned CW = cnt_width(K);

    logic [K-1:0][dw-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 out_valid;
    logic                 flush_pend;

    logic                 beat;
    logic                 drain;
    logic                 out_free;
    logic                 flush_req;
    logic                 load;
    logic [CW-1:0]        eff_cnt;
    logic [K-1:0][dw-1:0] pack_word;

    assign ack_in    = ~flush_pend & ((cnt < CW'(K - 1)) | ~out_valid);
    assign req_out   = out_valid;
    assign beat      = fire(req_in, ack_in);
    assign drain     = fire(out_valid, ack_out);
    assign out_free  = ~out_valid | drain;
    assign flush_req = flush | flush_pend;
    assign eff_cnt   = cnt + CW'(beat);

    // A full word always finds the out reg free: ack_in blocks the last lane while it is held.
    assign load = (eff_cnt == CW'(K)) | (flush_req & (eff_cnt != '0) & out_free);

    // Same lane mux serves completion and flush: held lanes, the current beat, then zeros.
    always_comb begin
        pack_word = '0;
        for (int i = 0; i < K; i++) begin
            if (CW'(i) < cnt) begin
                pack_word[i] = acc[i];
            end else if ((CW'(i) == cnt) && beat) begin
                pack_word[i] = d_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            flush_pend <= 1'b0;
            d_out      <= '0;
            n_out      <= '0;
        end else begin
            if (load) begin
                d_out     <= pack_word;
                n_out     <= eff_cnt;
                out_valid <= 1'b1;
                cnt       <= '0;
            end else begin
                if (drain) begin
                    out_valid <= 1'b0;
                end
                if (beat) begin
                    cnt <= eff_cnt;
                    for (int i = 0; i < K; i++) begin
                        if (cnt == CW'(i)) begin
                            acc[i] <= d_in;
                        end
                    end
                end
            end
            flush_pend <= flush_req & (eff_cnt != '0) & ~load;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (dw=8, K=4) with a drain-side scoreboard.
module tb_word_packer;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d_in;
    logic        req_in;
    logic        ack_in;
    logic        flush;
    logic [31:0] d_out;
    logic [2:0]  n_out;
    logic        req_out;
    logic        ack_out;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    word_packer #(.dw(8), .K(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .req_in  (req_in),
        .ack_in  (ack_in),
        .flush   (flush),
        .d_out   (d_out),
        .n_out   (n_out),
        .req_out (req_out),
        .ack_out (ack_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data, input logic [2:0] n);
        exp_t e;
        e.data = data;
        e.n    = n;
        sb.push_back(e);
    endtask

    // Present a word and hold it until accepted, bounded.
    task automatic send(input logic [7:0] d);
        int t = 0;
        req_in = 1'b1;
        d_in   = d;
        while (!ack_in && t < 20) begin
            cyc();
            t++;
        end
        if (!ack_in) check("send_timeout", 64'(ack_in), 64'd1);
        cyc();
    endtask

    // A drain happens on the coming edge; compare against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && req_out === 1'b1 && ack_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(d_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("drain_data", 64'(d_out), 64'(e.data));
                check("drain_n", 64'(n_out), 64'(e.n));
            end
        end
    end

    initial begin
        rst = 1'b1; req_in = 1'b0; d_in = '0; flush = 1'b0; ack_out = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_req_out", 64'(req_out), 64'd0);
        check("rst_ack_in", 64'(ack_in), 64'd1);
        check("rst_n_out", 64'(n_out), 64'd0);
        check("rst_d_out", 64'(d_out), 64'd0);

        // Back-to-back full word with consumer ready
        ack_out = 1'b1;
        send(8'h11); send(8'h22); send(8'h33);
        push(32'h4433_2211, 3'd4);
        send(8'h44);
        req_in = 1'b0;
        check("full_req_out", 64'(req_out), 64'd1);
        check("full_n_out", 64'(n_out), 64'd4);
        cyc();
        check("full_req_drop", 64'(req_out), 64'd0);

        // Continuous stream with consumer stalled: stall only at cnt==3 with word held
        ack_out = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        push(32'h0403_0201, 3'd4);
        send(8'h04);
        check("stream_ack_cnt0", 64'(ack_in), 64'd1);
        send(8'h05); send(8'h06); send(8'h07);
        req_in = 1'b1;
        d_in   = 8'h08;
        check("stream_stall", 64'(ack_in), 64'd0);
        check("stream_hold", 64'(d_out), 64'h0403_0201);
        push(32'h0807_0605, 3'd4);
        ack_out = 1'b1;
        cyc();
        check("stream_resume", 64'(ack_in), 64'd1);
        cyc();
        req_in = 1'b0;
        check("stream_second", 64'(req_out), 64'd1);
        cyc();

        // Flush alone after two beats
        send(8'hAA); send(8'hBB);
        req_in = 1'b0;
        push(32'h0000_BBAA, 3'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_n_out", 64'(n_out), 64'd2);
        check("flush_ack_in", 64'(ack_in), 64'd1);
        cyc();
        check("flush_done", 64'(req_out), 64'd0);

        // Flush with the third beat while the out reg is occupied
        ack_out = 1'b0;
        push(32'h0403_0201, 3'd4);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hAA); send(8'hBB);
        push(32'h00CC_BBAA, 3'd3);
        flush  = 1'b1;
        req_in = 1'b1;
        d_in   = 8'hCC;
        cyc();
        flush  = 1'b0;
        req_in = 1'b0;
        check("pend_ack_in", 64'(ack_in), 64'd0);
        cyc();
        check("pend_req_out", 64'(req_out), 64'd1);
        check("pend_hold", 64'(d_out), 64'h0403_0201);
        ack_out = 1'b1;
        cyc();
        check("pend_req_kept", 64'(req_out), 64'd1);
        check("pend_d_out", 64'(d_out), 64'h00CC_BBAA);
        check("pend_n_out", 64'(n_out), 64'd3);
        cyc();
        check("pend_clear_req", 64'(req_out), 64'd0);
        check("pend_clear_ack", 64'(ack_in), 64'd1);

        // Reset mid-word with a word waiting: both are discarded
        ack_out = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        req_in = 1'b0;
        check("prerst_req_out", 64'(req_out), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_req_out", 64'(req_out), 64'd0);
        check("midrst_ack_in", 64'(ack_in), 64'd1);
        check("midrst_n_out", 64'(n_out), 64'd0);
        check("midrst_d_out", 64'(d_out), 64'd0);
        ack_out = 1'b1;
        send(8'h71); send(8'h72); send(8'h73);
        push(32'h7473_7271, 3'd4);
        send(8'h74);
        req_in = 1'b0;
        check("fresh_d_out", 64'(d_out), 64'h7473_7271);
        cyc();
        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
